// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with almost-full/empty thresholds, overflow/underflow pulses, occupancy count, optional FWFT.
// Latency: count/flags update one edge after a write; read data after one edge (FWFT=0) or at the head (FWFT=1).
// Backpressure: writes refused while full, reads refused while empty; a refusal pulses overflow_o/underflow_o next cycle.
module sync_fifo_ext #(
    parameter int FIFO_DEPTH          = 16,
    parameter int DATA_WIDTH          = 8,
    parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESH = 2,
    parameter int FWFT                = 0,
    localparam int CW                 = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic                  underflow_o,
    output logic [CW-1:0]         count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_ext: FIFO_DEPTH must be >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_ext: DATA_WIDTH must be >= 1");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("sync_fifo_ext: ALMOST_FULL_THRESH must be in 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ext: ALMOST_EMPTY_THRESH must be in 0..FIFO_DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo_ext: FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Depth need not be a power of two, so pointers wrap at FIFO_DEPTH-1 explicitly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o         = (count_q == CW'(FIFO_DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CW'(ALMOST_FULL_THRESH));
    assign almost_empty_o = (count_q <= CW'(ALMOST_EMPTY_THRESH));
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // Acceptance looks only at registered flags: a same-cycle pop never frees room for a push.
    assign wr_acc = we_i && !full_o;
    assign rd_acc = re_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= we_i && full_o;
            underflow_q <= re_i && empty_o;
        end
    end

    if (FWFT == 0) begin : g_std
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= mem[rd_ptr_q];
                end
            end
        end

        assign data_o  = data_q;
        assign valid_o = valid_q;
    end else begin : g_fwft
        // Head is presented directly; forced to zero while empty so the idle value is deterministic.
        assign data_o  = empty_o ? '0 : mem[rd_ptr_q];
        assign valid_o = !empty_o;
    end

    a_count_range : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CW'(FIFO_DEPTH));
    a_wr_ptr_range : assert property (@(posedge clk_i) disable iff (rst_i)
        wr_ptr_q <= PW'(FIFO_DEPTH - 1));
    a_rd_ptr_range : assert property (@(posedge clk_i) disable iff (rst_i)
        rd_ptr_q <= PW'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard-read and an FWFT instance share one stimulus stream;
// a queue model is compared every cycle, and directed steps pin literal expectations.
module tb_sync_fifo_ext;

    localparam int D  = 5;
    localparam int W  = 8;
    localparam int CW = $clog2(D + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic         re;
    logic [W-1:0] din;

    logic [W-1:0]  a_data, b_data;
    logic          a_valid, b_valid, a_full, b_full, a_af, b_af, a_ovf, b_ovf;
    logic          a_empty, b_empty, a_ae, b_ae, a_udf, b_udf;
    logic [CW-1:0] a_cnt, b_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.FIFO_DEPTH(D), .DATA_WIDTH(W), .ALMOST_FULL_THRESH(4),
                    .ALMOST_EMPTY_THRESH(1), .FWFT(0)) u_std (
        .clk_i(clk), .rst_i(rst), .we_i(we), .data_i(din),
        .full_o(a_full), .almost_full_o(a_af), .overflow_o(a_ovf),
        .re_i(re), .data_o(a_data), .valid_o(a_valid), .empty_o(a_empty),
        .almost_empty_o(a_ae), .underflow_o(a_udf), .count_o(a_cnt)
    );

    sync_fifo_ext #(.FIFO_DEPTH(D), .DATA_WIDTH(W), .ALMOST_FULL_THRESH(4),
                    .ALMOST_EMPTY_THRESH(1), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .we_i(we), .data_i(din),
        .full_o(b_full), .almost_full_o(b_af), .overflow_o(b_ovf),
        .re_i(re), .data_o(b_data), .valid_o(b_valid), .empty_o(b_empty),
        .almost_empty_o(b_ae), .underflow_o(b_udf), .count_o(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs derived from its size and the handshake rules.
    logic [W-1:0] q[$];
    logic [W-1:0] m_data;
    logic         m_valid, m_ovf, m_udf;

    always @(posedge clk) begin
        int n;
        n = q.size();
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            m_ovf   = we && (n == D);
            m_udf   = re && (n == 0);
            m_valid = re && (n != 0);
            if (m_valid) m_data = q.pop_front();
            if (we && n != D) q.push_back(din);
        end
    end

    always @(negedge clk) begin
        int n;
        logic [W-1:0] head;
        n = q.size();
        head = (n != 0) ? q[0] : '0;
        if (chk_en) begin
            chk("m_count_a", 32'(a_cnt), 32'(n));
            chk("m_count_b", 32'(b_cnt), 32'(n));
            chk("m_full_a", 32'(a_full), 32'(n == D));
            chk("m_full_b", 32'(b_full), 32'(n == D));
            chk("m_empty_a", 32'(a_empty), 32'(n == 0));
            chk("m_empty_b", 32'(b_empty), 32'(n == 0));
            chk("m_afull_a", 32'(a_af), 32'(n >= 4));
            chk("m_afull_b", 32'(b_af), 32'(n >= 4));
            chk("m_aempty_a", 32'(a_ae), 32'(n <= 1));
            chk("m_aempty_b", 32'(b_ae), 32'(n <= 1));
            chk("m_ovf_a", 32'(a_ovf), 32'(m_ovf));
            chk("m_ovf_b", 32'(b_ovf), 32'(m_ovf));
            chk("m_udf_a", 32'(a_udf), 32'(m_udf));
            chk("m_udf_b", 32'(b_udf), 32'(m_udf));
            chk("m_data_a", 32'(a_data), 32'(m_data));
            chk("m_valid_a", 32'(a_valid), 32'(m_valid));
            chk("m_data_b", 32'(b_data), 32'(head));
            chk("m_valid_b", 32'(b_valid), 32'(n != 0));
        end
    end

    task automatic cycle(input logic r, input logic w, input logic [W-1:0] d, input logic rd);
        rst = r;
        we  = w;
        din = d;
        re  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(a_cnt), 32'd0);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_aempty"}, 32'(a_ae), 32'd1);
        chk({tag, "_full"}, 32'(a_full), 32'd0);
        chk({tag, "_afull"}, 32'(a_af), 32'd0);
        chk({tag, "_ovf"}, 32'(a_ovf), 32'd0);
        chk({tag, "_udf"}, 32'(a_udf), 32'd0);
        chk({tag, "_valid"}, 32'(a_valid), 32'd0);
        chk({tag, "_data"}, 32'(a_data), 32'd0);
        chk({tag, "_fwft_valid"}, 32'(b_valid), 32'd0);
        chk({tag, "_fwft_data"}, 32'(b_data), 32'd0);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk_reset_state("rst");

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b1, 8'(i), 1'b0);
            chk("fill_count", 32'(a_cnt), 32'(i));
            chk("fill_aempty", 32'(a_ae), 32'(i < 2));
            chk("fill_afull", 32'(a_af), 32'(i >= 4));
            chk("fill_full", 32'(a_full), 32'(i == 5));
            chk("fill_fwft_head", 32'(b_data), 32'h01);
        end
        cycle(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ovf_pulse", 32'(a_ovf), 32'd1);
        chk("ovf_count", 32'(a_cnt), 32'd5);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(a_ovf), 32'd0);

        // Drain and underflow
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_data", 32'(a_data), 32'(i));
            chk("drain_valid", 32'(a_valid), 32'd1);
        end
        chk("drain_empty", 32'(a_empty), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_pulse", 32'(a_udf), 32'd1);
        chk("udf_data_hold", 32'(a_data), 32'h05);
        chk("udf_valid", 32'(a_valid), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("udf_clear", 32'(a_udf), 32'd0);
        chk("idle_data_hold", 32'(a_data), 32'h05);

        // Wrap-around at constant occupancy 3
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b1, 8'(8'h13 + k), 1'b1);
            chk("wrap_data", 32'(a_data), 32'(8'h10 + k));
            chk("wrap_valid", 32'(a_valid), 32'd1);
            chk("wrap_count", 32'(a_cnt), 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_tail", 32'(a_data), 32'(8'h1C + k));
        end

        // Full with simultaneous write and read
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 8'h77, 1'b1);
        chk("fullrw_data", 32'(a_data), 32'h01);
        chk("fullrw_ovf", 32'(a_ovf), 32'd1);
        chk("fullrw_count", 32'(a_cnt), 32'd4);
        chk("fullrw_fwft_head", 32'(b_data), 32'h02);
        for (int i = 2; i <= 5; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            chk("fullrw_drain", 32'(a_data), 32'(i));
        end
        chk("fullrw_empty", 32'(a_empty), 32'd1);

        // FWFT presentation
        cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_empty", 32'(b_empty), 32'd0);
        chk("fwft_valid", 32'(b_valid), 32'd1);
        chk("fwft_data", 32'(b_data), 32'hA5);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft_hold", 32'(b_data), 32'hA5);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", 32'(b_empty), 32'd1);
        chk("fwft_pop_valid", 32'(b_valid), 32'd0);
        chk("std_after_pop", 32'(a_data), 32'hA5);

        // Reset mid-operation, then write/read with the read rejected on empty
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h21 + i), 1'b0);
        chk("pre_rst_count", 32'(a_cnt), 32'd3);
        cycle(1'b1, 1'b1, 8'h99, 1'b0);
        chk_reset_state("midrst");
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("post_rst_udf", 32'(a_udf), 32'd1);
        chk("post_rst_count", 32'(a_cnt), 32'd1);
        chk("post_rst_fwft", 32'(b_data), 32'h3C);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_data", 32'(a_data), 32'h3C);
        chk("post_rst_valid", 32'(a_valid), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", 32'(a_empty), 32'd1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
